// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI3 write arbiter.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

package axi_arb_pkg;
  typedef enum logic {IDLE, GRANT} aw_state_e;

  // Bit of the slave-side ID that carries the originating master index
  localparam int MST_IDX_BIT = 3;
  localparam int NUM_MST     = 2;
endpackage

// File: rtl/axi_arb_ord_fifo.sv
// Order FIFO: remembers which master owns each accepted AW so W bursts
// are forwarded in grant order. Entries are a single master-index bit.
module axi_arb_ord_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0]  wr_q;
  logic [PW-1:0]  rd_q;
  logic [PW:0]    cnt_q;
  logic [DEPTH-1:0] mem_q;

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage holds only master indices; contents are meaningless while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];
endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI3 write arbiter: round-robin AW grant,
// W routed by grant order, B routed back by the inserted ID bit.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W    = `ADDR_BUS_WIDTH,
  parameter int DATA_W    = `DATA_BUS_WIDTH,
  parameter int ORD_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              arst,
  // master 0 AW / W / B
  input  logic [3:0]        m0_awid,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic [3:0]        m0_awlen,
  input  logic [2:0]        m0_awsize,
  input  logic [1:0]        m0_awburst,
  input  logic [1:0]        m0_awlock,
  input  logic [3:0]        m0_awcache,
  input  logic [2:0]        m0_awprot,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [3:0]        m0_wid,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic              m0_wlast,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic [3:0]        m0_bid,
  output logic [1:0]        m0_bresp,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  // master 1 AW / W / B
  input  logic [3:0]        m1_awid,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [3:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic [1:0]        m1_awlock,
  input  logic [3:0]        m1_awcache,
  input  logic [2:0]        m1_awprot,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [3:0]        m1_wid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic              m1_wlast,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [3:0]        m1_bid,
  output logic [1:0]        m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  // slave AW / W / B
  output logic [3:0]        s_awid,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [3:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic [1:0]        s_awlock,
  output logic [3:0]        s_awcache,
  output logic [2:0]        s_awprot,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [3:0]        s_wid,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic              s_wlast,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [3:0]        s_bid,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready
);
  aw_state_e state_q;
  logic      gnt_q;
  logic      rr_q;
  logic      aw_hs;
  logic      w_pop;
  logic      ord_full;
  logic      ord_empty;
  logic      ord_head;
  logic      b_sel;
  logic      in_grant;
  logic      unused_id_msb;

  // Masters only use IDs 0-7; their top ID bit is replaced by the master index
  assign unused_id_msb = ^{m0_awid[MST_IDX_BIT], m1_awid[MST_IDX_BIT],
                           m0_wid[MST_IDX_BIT],  m1_wid[MST_IDX_BIT]};

  assign in_grant = (state_q == GRANT);
  assign aw_hs    = s_awvalid & s_awready;

  // AW FSM: pick a winner in IDLE (round-robin on contention), hold it until the slave handshake
  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((m0_awvalid | m1_awvalid) && !ord_full) begin
            state_q <= GRANT;
            gnt_q   <= (m0_awvalid & m1_awvalid) ? rr_q : m1_awvalid;
          end
        end
        GRANT: begin
          if (aw_hs) begin
            state_q <= IDLE;
            rr_q    <= ~gnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_awvalid  = in_grant & (gnt_q ? m1_awvalid : m0_awvalid);
  assign s_awid     = {gnt_q, (gnt_q ? m1_awid[2:0] : m0_awid[2:0])};
  assign s_awaddr   = gnt_q ? m1_awaddr  : m0_awaddr;
  assign s_awlen    = gnt_q ? m1_awlen   : m0_awlen;
  assign s_awsize   = gnt_q ? m1_awsize  : m0_awsize;
  assign s_awburst  = gnt_q ? m1_awburst : m0_awburst;
  assign s_awlock   = gnt_q ? m1_awlock  : m0_awlock;
  assign s_awcache  = gnt_q ? m1_awcache : m0_awcache;
  assign s_awprot   = gnt_q ? m1_awprot  : m0_awprot;
  assign m0_awready = in_grant & ~gnt_q & s_awready;
  assign m1_awready = in_grant &  gnt_q & s_awready;

  axi_arb_ord_fifo #(
    .DEPTH(ORD_DEPTH)
  ) u_ord_fifo (
    .clk      (aclk),
    .rst_n    (arst),
    .push     (aw_hs),
    .push_data(gnt_q),
    .pop      (w_pop),
    .full     (ord_full),
    .empty    (ord_empty),
    .head     (ord_head)
  );

  // W path follows the FIFO head; a burst ends on the wlast handshake alone
  assign s_wvalid  = ~ord_empty & (ord_head ? m1_wvalid : m0_wvalid);
  assign s_wid     = {ord_head, (ord_head ? m1_wid[2:0] : m0_wid[2:0])};
  assign s_wdata   = ord_head ? m1_wdata : m0_wdata;
  assign s_wstrb   = ord_head ? m1_wstrb : m0_wstrb;
  assign s_wlast   = ord_head ? m1_wlast : m0_wlast;
  assign m0_wready = ~ord_empty & ~ord_head & s_wready;
  assign m1_wready = ~ord_empty &  ord_head & s_wready;
  assign w_pop     = s_wvalid & s_wready & s_wlast;

  // B path routed by the master-index bit inserted on AW; valids are held low during reset
  assign b_sel     = s_bid[MST_IDX_BIT];
  assign m0_bvalid = arst & s_bvalid & ~b_sel;
  assign m1_bvalid = arst & s_bvalid &  b_sel;
  assign m0_bid    = {1'b0, s_bid[2:0]};
  assign m1_bid    = {1'b0, s_bid[2:0]};
  assign m0_bresp  = s_bresp;
  assign m1_bresp  = s_bresp;
  assign s_bready  = b_sel ? m1_bready : m0_bready;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with hand-computed expectations.
module tb_axi_wr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk, arst;
  logic [3:0] m0_awid, m1_awid, m0_awlen, m1_awlen, m0_awcache, m1_awcache;
  logic [AW-1:0] m0_awaddr, m1_awaddr;
  logic [2:0] m0_awsize, m1_awsize, m0_awprot, m1_awprot;
  logic [1:0] m0_awburst, m1_awburst, m0_awlock, m1_awlock;
  logic m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic [3:0] m0_wid, m1_wid;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW/8-1:0] m0_wstrb, m1_wstrb;
  logic m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
  logic [3:0] m0_bid, m1_bid;
  logic [1:0] m0_bresp, m1_bresp;
  logic m0_bvalid, m1_bvalid, m0_bready, m1_bready;
  logic [3:0] s_awid, s_awlen, s_awcache;
  logic [AW-1:0] s_awaddr;
  logic [2:0] s_awsize, s_awprot;
  logic [1:0] s_awburst, s_awlock;
  logic s_awvalid, s_awready;
  logic [3:0] s_wid;
  logic [DW-1:0] s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic s_wlast, s_wvalid, s_wready;
  logic [3:0] s_bid;
  logic [1:0] s_bresp;
  logic s_bvalid, s_bready;

  int n_chk = 0;
  int n_bad = 0;

  axi_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ORD_DEPTH(4)) dut (
    .aclk(aclk), .arst(arst),
    .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
    .m0_awburst(m0_awburst), .m0_awlock(m0_awlock), .m0_awcache(m0_awcache), .m0_awprot(m0_awprot),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wid(m0_wid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst), .m1_awlock(m1_awlock), .m1_awcache(m1_awcache), .m1_awprot(m1_awprot),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wid(m1_wid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic clear_inputs();
    m0_awid = 0; m0_awaddr = 0; m0_awlen = 0; m0_awsize = 3'd2; m0_awburst = 2'd1;
    m0_awlock = 0; m0_awcache = 0; m0_awprot = 0; m0_awvalid = 0;
    m1_awid = 0; m1_awaddr = 0; m1_awlen = 0; m1_awsize = 3'd2; m1_awburst = 2'd1;
    m1_awlock = 0; m1_awcache = 0; m1_awprot = 0; m1_awvalid = 0;
    m0_wid = 0; m0_wdata = 0; m0_wstrb = '1; m0_wlast = 0; m0_wvalid = 0;
    m1_wid = 0; m1_wdata = 0; m1_wstrb = '1; m1_wlast = 0; m1_wvalid = 0;
    m0_bready = 1; m1_bready = 1;
    s_awready = 1; s_wready = 1;
    s_bid = 0; s_bresp = 0; s_bvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    arst = 1'b0;
    #3;
    arst = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    arst = 1'b0;
    #3;
    // reset state
    chk("rst_m0_awready", m0_awready, 0);
    chk("rst_m1_awready", m1_awready, 0);
    chk("rst_m0_wready", m0_wready, 0);
    chk("rst_m1_wready", m1_wready, 0);
    chk("rst_m0_bvalid", m0_bvalid, 0);
    chk("rst_m1_bvalid", m1_bvalid, 0);
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_wvalid", s_wvalid, 0);
    arst = 1'b1;
    tick();

    // single AW, 4 beats
    m0_awid = 4'd3; m0_awlen = 4'd3; m0_awaddr = 32'h100; m0_awvalid = 1; s_awready = 0;
    #1;
    chk("t1_awvalid_idle", s_awvalid, 0);
    tick();
    chk("t1_s_awvalid", s_awvalid, 1);
    chk("t1_s_awid", s_awid, 3);
    chk("t1_s_awaddr", s_awaddr, 32'h100);
    chk("t1_s_awlen", s_awlen, 3);
    chk("t1_m0_awready_wait", m0_awready, 0);
    s_awready = 1;
    #1;
    chk("t1_m0_awready", m0_awready, 1);
    chk("t1_m1_awready", m1_awready, 0);
    tick();
    m0_awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      m0_wid = 4'd3; m0_wdata = 32'hA000_0000 + i; m0_wvalid = 1; m0_wlast = (i == 3);
      #1;
      chk("t1_s_wvalid", s_wvalid, 1);
      chk("t1_s_wid", s_wid, 3);
      chk("t1_s_wdata", s_wdata, 32'hA000_0000 + i);
      chk("t1_m0_wready", m0_wready, 1);
      tick();
    end
    #1;
    chk("t1_s_wvalid_after", s_wvalid, 0);
    chk("t1_m0_wready_after", m0_wready, 0);
    m0_wvalid = 0; m0_wlast = 0;
    s_bvalid = 1; s_bid = 4'd3; s_bresp = 2'd0; m0_bready = 1; m1_bready = 0;
    #1;
    chk("t1_m0_bvalid", m0_bvalid, 1);
    chk("t1_m0_bid", m0_bid, 3);
    chk("t1_m1_bvalid", m1_bvalid, 0);
    chk("t1_s_bready", s_bready, 1);
    tick();
    s_bvalid = 0;

    // simultaneous requests after reset
    do_reset();
    m0_awid = 4'd5; m1_awid = 4'd6; m1_wdata = 32'hBEEF_0001; m0_awvalid = 1; m1_awvalid = 1;
    tick();
    chk("t2_first_awid", s_awid, 4'd5);
    chk("t2_m0_awready", m0_awready, 1);
    chk("t2_m1_awready", m1_awready, 0);
    tick();
    m0_awvalid = 0;
    #1;
    chk("t2_idle_awvalid", s_awvalid, 0);
    tick();
    chk("t2_second_awid", s_awid, 4'd14);
    chk("t2_m1_awready", m1_awready, 1);
    tick();
    m1_awvalid = 0;
    m1_wid = 4'd6; m1_wvalid = 1; m1_wlast = 1;
    m0_wid = 4'd5; m0_wdata = 32'h0000_5555; m0_wvalid = 1; m0_wlast = 0;
    #1;
    chk("t2_m1_wready_hold", m1_wready, 0);
    chk("t2_m0_wready", m0_wready, 1);
    chk("t2_s_wid_m0", s_wid, 5);
    tick();
    m0_wlast = 1;
    #1;
    chk("t2_m1_wready_hold2", m1_wready, 0);
    tick();
    m0_wvalid = 0; m0_wlast = 0;
    #1;
    chk("t2_m1_wready", m1_wready, 1);
    chk("t2_s_wid_m1", s_wid, 4'd14);
    chk("t2_s_wdata_m1", s_wdata, 32'hBEEF_0001);
    tick();
    m1_wvalid = 0; m1_wlast = 0;
    #1;
    chk("t2_drained", s_wvalid, 0);

    // fairness over 8 grants with W draining alongside
    do_reset();
    m0_awid = 4'd1; m1_awid = 4'd2; m0_awvalid = 1; m1_awvalid = 1;
    m0_wvalid = 1; m0_wlast = 1; m1_wvalid = 1; m1_wlast = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("fair_awvalid", s_awvalid, 1);
      chk("fair_gnt", s_awid, (i % 2 == 0) ? 32'd1 : 32'd10);
      tick();
    end
    m0_awvalid = 0; m1_awvalid = 0;
    tick();
    #1;
    chk("fair_fifo_empty", s_wvalid, 0);
    m0_wvalid = 0; m1_wvalid = 0; m0_wlast = 0; m1_wlast = 0;

    // order FIFO full
    do_reset();
    m0_awid = 4'd2; m0_awvalid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
    end
    tick();
    chk("full_s_awvalid", s_awvalid, 0);
    chk("full_m0_awready", m0_awready, 0);
    tick();
    chk("full_s_awvalid2", s_awvalid, 0);
    m0_wvalid = 1; m0_wlast = 1;
    #1;
    chk("full_m0_wready", m0_wready, 1);
    tick();
    m0_wvalid = 0; m0_wlast = 0;
    chk("full_pop_edge_idle", s_awvalid, 0);
    tick();
    chk("full_fifth_granted", s_awvalid, 1);
    chk("full_fifth_awready", m0_awready, 1);

    // out-of-order B
    do_reset();
    s_bvalid = 1; s_bid = 4'd9; s_bresp = 2'd2; m0_bready = 1; m1_bready = 0;
    #1;
    chk("b_m1_bvalid", m1_bvalid, 1);
    chk("b_m1_bid", m1_bid, 1);
    chk("b_m1_bresp", m1_bresp, 2);
    chk("b_m0_bvalid_low", m0_bvalid, 0);
    chk("b_s_bready_m1_low", s_bready, 0);
    m1_bready = 1;
    #1;
    chk("b_s_bready_m1", s_bready, 1);
    tick();
    s_bid = 4'd2; s_bresp = 2'd0;
    #1;
    chk("b_m0_bvalid", m0_bvalid, 1);
    chk("b_m0_bid", m0_bid, 2);
    chk("b_m1_bvalid_low", m1_bvalid, 0);
    chk("b_s_bready_m0", s_bready, 1);
    m0_bready = 0;
    #1;
    chk("b_s_bready_m0_low", s_bready, 0);
    s_bvalid = 0;

    // reset mid-burst
    do_reset();
    m0_awid = 4'd1; m0_awlen = 4'd3; m0_awvalid = 1;
    tick();
    tick();
    m0_awvalid = 0;
    m0_wvalid = 1; m0_wlast = 0;
    tick();
    tick();
    m0_awvalid = 1;
    #1;
    chk("mid_wready_before", m0_wready, 1);
    arst = 1'b0;
    #1;
    chk("mid_m0_awready", m0_awready, 0);
    chk("mid_m0_wready", m0_wready, 0);
    chk("mid_s_wvalid", s_wvalid, 0);
    chk("mid_s_awvalid", s_awvalid, 0);
    chk("mid_m0_bvalid", m0_bvalid, 0);
    #1;
    arst = 1'b1;
    m0_wvalid = 0; m0_awid = 4'd4;
    tick();
    chk("mid_new_awvalid", s_awvalid, 1);
    chk("mid_new_awid", s_awid, 4);
    chk("mid_new_awready", m0_awready, 1);
    tick();
    m0_awvalid = 0;
    #1;
    chk("mid_new_done", s_awvalid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
